fir_mc_engine: RTL and testbench

Parametrised multi-channel direct-form FIR engine, the successor to the single-channel fixed-width filter. It holds runtime-writable coefficients shared by NCH channels and a per-channel sample buffer and output buffer. A START operation filters every channel back-to-back with one MAC per cycle, then scales, saturates and stores the results. A host reads results by address through the same operation bus.

---
 rtl/fir_mc_pkg.sv | 48 ++++
 rtl/fir_mc_if.sv | 22 ++
 rtl/fir_mac_unit.sv | 40 ++++
 rtl/fir_mc_engine.sv | 207 ++++++++++++++++++++
 tb/tb_fir_mc_engine.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fir_mc_pkg.sv
// Shared types and the shift/saturate helpers for the multi-channel FIR engine.
package fir_mc_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned ACC_MAX = 128;

    typedef enum logic [OP_W-1:0] {
        OP_NOP       = 3'b000,
        OP_WR_SAMPLE = 3'b001,
        OP_START     = 3'b010,
        OP_RD_OUT    = 3'b011,
        OP_WR_COEF   = 3'b100,
        OP_CLEAR     = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        WB,
        CLR
    } state_e;

    // Arithmetic shift then clip to the signed dw-bit range; result sign-extended to ACC_MAX.
    function automatic logic signed [ACC_MAX-1:0] sat_shift(
        input logic signed [ACC_MAX-1:0] acc,
        input int unsigned               shift,
        input int unsigned               dw
    );
        logic signed [ACC_MAX-1:0] s;
        logic signed [ACC_MAX-1:0] hi;
        logic signed [ACC_MAX-1:0] lo;
        s  = acc >>> shift;
        hi = $signed((ACC_MAX'(1) << (dw - 1)) - ACC_MAX'(1));
        lo = ~hi;
        if (s > hi)      return hi;
        else if (s < lo) return lo;
        else             return s;
    endfunction

    function automatic logic sat_clips(
        input logic signed [ACC_MAX-1:0] acc,
        input int unsigned               shift,
        input int unsigned               dw
    );
        return sat_shift(acc, shift, dw) != (acc >>> shift);
    endfunction

endpackage

// File: rtl/fir_mc_if.sv
// Host operation bus of the FIR engine: op/ch/addr/din in, read data and status out.
interface fir_mc_if
    import fir_mc_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned CHW  = 1,
    parameter int unsigned DINW = 32
);
    logic [OP_W-1:0] op;
    logic [CHW-1:0]  ch;
    logic [31:0]     addr;
    logic [DINW-1:0] din;
    logic [DW-1:0]   y;
    logic            y_valid;
    logic            busy;
    logic            done;
    logic            sat;
    logic            err;

    modport master (output op, ch, addr, din, input y, y_valid, busy, done, sat, err);
    modport slave  (input op, ch, addr, din, output y, y_valid, busy, done, sat, err);
endinterface

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate with clear, plus combinational shift/saturate of the accumulator.
module fir_mac_unit
    import fir_mc_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned CW    = 32,
    parameter int unsigned AW    = 72,
    parameter int unsigned SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 acc_en,
    input  logic                 acc_clr,
    input  logic signed [CW-1:0] coef,
    input  logic signed [DW-1:0] samp,
    output logic [DW-1:0]        y_c,
    output logic                 sat_hit_c
);
    localparam int unsigned PW = DW + CW;

    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] acc_q;

    always_comb begin
        prod  = PW'(coef) * PW'(samp);
        acc_d = acc_q;
        if (acc_clr)     acc_d = '0;
        else if (acc_en) acc_d = acc_q + AW'(prod);
    end

    always_ff @(posedge clk) begin
        if (!reset) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign y_c       = DW'(sat_shift(ACC_MAX'(acc_q), SHIFT, DW));
    assign sat_hit_c = sat_clips(ACC_MAX'(acc_q), SHIFT, DW);

endmodule

// File: rtl/fir_mc_engine.sv
// Multi-channel direct-form FIR engine: host ops in IDLE, MAC/WB run over all channels, CLR wipe.
module fir_mc_engine
    import fir_mc_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned CW    = 32,
    parameter int unsigned AW    = 72,
    parameter int unsigned NTAPS = 100,
    parameter int unsigned NSAMP = 1000,
    parameter int unsigned NCH   = 2,
    parameter int unsigned SHIFT = 0
) (
    input  logic    clk,
    input  logic    reset,
    fir_mc_if.slave bus
);
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned NW  = (NSAMP > 1) ? $clog2(NSAMP) : 1;
    localparam int unsigned KW  = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    logic signed [DW-1:0] x_mem   [NCH][NSAMP];
    logic signed [CW-1:0] h_mem   [NTAPS];
    logic        [DW-1:0] out_mem [NCH][NSAMP];

    state_e         state_q, state_d;
    logic [NW-1:0]  n_q, n_d;
    logic [KW-1:0]  k_q, k_d;
    logic [CHW-1:0] c_q, c_d;
    logic [DW-1:0]  y_q, y_d;
    logic           y_valid_q, y_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           sat_q, sat_d;
    logic           err_q, err_d;

    logic                 acc_en, acc_clr, x_we, h_we, out_we, clr_we;
    logic                 samp_bad, coef_bad, n_lt_k;
    logic [NW-1:0]        tap_idx;
    logic signed [DW-1:0] samp_sel;
    logic [DW-1:0]        mac_y_c;
    logic                 sat_hit_c;
    op_e                  op_in;

    assign op_in    = op_e'(bus.op);
    assign samp_bad = (bus.addr >= 32'(NSAMP)) || (32'(bus.ch) >= 32'(NCH));
    assign coef_bad = bus.addr >= 32'(NTAPS);
    // History before the first sample is implicit zero.
    assign n_lt_k   = 32'(n_q) < 32'(k_q);
    assign tap_idx  = n_q - NW'(k_q);
    assign samp_sel = n_lt_k ? '0 : x_mem[c_q][tap_idx];

    fir_mac_unit #(.DW(DW), .CW(CW), .AW(AW), .SHIFT(SHIFT)) u_mac (
        .clk       (clk),
        .reset     (reset),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .coef      (h_mem[k_q]),
        .samp      (samp_sel),
        .y_c       (mac_y_c),
        .sat_hit_c (sat_hit_c)
    );

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        c_d       = c_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        done_d    = done_q;
        sat_d     = sat_q;
        err_d     = 1'b0;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        x_we      = 1'b0;
        h_we      = 1'b0;
        out_we    = 1'b0;
        clr_we    = 1'b0;

        case (state_q)
            IDLE: begin
                case (op_in)
                    OP_NOP: ;
                    OP_WR_SAMPLE: begin
                        if (samp_bad) err_d = 1'b1;
                        else          x_we  = 1'b1;
                    end
                    OP_RD_OUT: begin
                        y_valid_d = 1'b1;
                        if (samp_bad) begin
                            err_d = 1'b1;
                            y_d   = '0;
                        end else begin
                            y_d = out_mem[bus.ch][NW'(bus.addr)];
                        end
                    end
                    OP_WR_COEF: begin
                        if (coef_bad) err_d = 1'b1;
                        else          h_we  = 1'b1;
                    end
                    OP_START: begin
                        done_d  = 1'b0;
                        sat_d   = 1'b0;
                        n_d     = '0;
                        k_d     = '0;
                        c_d     = '0;
                        acc_clr = 1'b1;
                        state_d = MAC;
                    end
                    OP_CLEAR: begin
                        done_d  = 1'b0;
                        sat_d   = 1'b0;
                        n_d     = '0;
                        state_d = CLR;
                    end
                    default: err_d = 1'b1;
                endcase
            end
            MAC: begin
                acc_en = 1'b1;
                if (k_q == KW'(NTAPS - 1)) state_d = WB;
                else                       k_d     = k_q + KW'(1);
            end
            WB: begin
                out_we  = 1'b1;
                acc_clr = 1'b1;
                k_d     = '0;
                if (sat_hit_c) sat_d = 1'b1;
                state_d = MAC;
                if (n_q == NW'(NSAMP - 1)) begin
                    n_d = '0;
                    if (c_q == CHW'(NCH - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        c_d = c_q + CHW'(1);
                    end
                end else begin
                    n_d = n_q + NW'(1);
                end
            end
            CLR: begin
                clr_we = 1'b1;
                if (n_q == NW'(NSAMP - 1)) begin
                    n_d     = '0;
                    state_d = IDLE;
                end else begin
                    n_d = n_q + NW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Any op while a run or clear is in flight is refused without side effects.
        if (state_q != IDLE && op_in != OP_NOP) err_d = 1'b1;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            n_q       <= '0;
            k_q       <= '0;
            c_q       <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            k_q       <= k_d;
            c_q       <= c_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sat_q     <= sat_d;
            err_q     <= err_d;
        end
    end

    // Memories survive reset; reset only suppresses writes in its own cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (x_we)   x_mem[bus.ch][NW'(bus.addr)] <= bus.din[DW-1:0];
            if (h_we)   h_mem[KW'(bus.addr)]         <= bus.din[CW-1:0];
            if (out_we) out_mem[c_q][n_q]            <= mac_y_c;
            if (clr_we) begin
                for (int c = 0; c < NCH; c++) begin
                    x_mem[c][n_q]   <= '0;
                    out_mem[c][n_q] <= '0;
                end
            end
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sat     = sat_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_fir_mc_engine.sv
// Randomized and directed bench for fir_mc_engine against a behavioural filter model.
module tb_fir_mc_engine;
    import fir_mc_pkg::*;

    localparam int unsigned DW = 16, CW = 16, AW = 40;
    localparam int unsigned NTAPS = 4, NSAMP = 8, NCH = 2, SHIFT = 0;
    localparam int RUN_CYC = NCH * NSAMP * (NTAPS + 1);
    localparam int LIMIT   = 400;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fir_mc_if #(.DW(DW), .CHW(1), .DINW(16)) bus ();

    fir_mc_engine #(
        .DW(DW), .CW(CW), .AW(AW), .NTAPS(NTAPS), .NSAMP(NSAMP), .NCH(NCH), .SHIFT(SHIFT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [15:0] mx   [NCH][NSAMP];
    logic signed [15:0] mh   [NTAPS];
    logic signed [15:0] mout [NCH][NSAMP];
    bit                 msat;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic ch, input int unsigned addr,
                         input logic [15:0] din);
        bus.op   = op;
        bus.ch   = ch;
        bus.addr = addr;
        bus.din  = din;
        @(posedge clk);
        #1;
        bus.op = OP_NOP;
    endtask

    task automatic wr_sample(input int c, input int i, input logic [15:0] v);
        do_op(OP_WR_SAMPLE, 1'(c), i, v);
        mx[c][i] = $signed(v);
    endtask

    task automatic wr_coef(input int i, input logic [15:0] v);
        do_op(OP_WR_COEF, 1'b0, i, v);
        mh[i] = $signed(v);
    endtask

    // Convolution with zero history, shift, and clip to 16-bit signed.
    function automatic void model_run();
        longint acc;
        msat = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            for (int n = 0; n < NSAMP; n++) begin
                acc = 0;
                for (int k = 0; k < NTAPS; k++)
                    if (n >= k) acc += longint'(mh[k]) * longint'(mx[c][n-k]);
                acc = acc >>> SHIFT;
                if (acc > 32767) begin
                    mout[c][n] = 16'sh7FFF;
                    msat = 1'b1;
                end else if (acc < -32768) begin
                    mout[c][n] = 16'sh8000;
                    msat = 1'b1;
                end else begin
                    mout[c][n] = 16'(acc);
                end
            end
        end
    endfunction

    task automatic read_all(input string tag);
        for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < NSAMP; i++) begin
                do_op(OP_RD_OUT, 1'(c), i, 16'h0);
                check_eq($sformatf("%s_vld_%0d_%0d", tag, c, i), bus.y_valid, 1);
                check_eq($sformatf("%s_y_%0d_%0d", tag, c, i), bus.y, $unsigned(mout[c][i]));
            end
        end
    endtask

    task automatic run_check(input bit intrude, input string tag);
        int cyc;
        do_op(OP_START, 1'b0, 0, 16'h0);
        check_eq({tag, "_busy"}, bus.busy, 1);
        check_eq({tag, "_start_err"}, bus.err, 0);
        cyc = 0;
        while (!bus.done && cyc < LIMIT) begin
            if (intrude && cyc == 5) begin
                bus.op   = OP_WR_SAMPLE;
                bus.ch   = 1'b0;
                bus.addr = 2;
                bus.din  = 16'h5555;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (intrude && cyc == 6) check_eq({tag, "_busy_err"}, bus.err, 1);
            bus.op = OP_NOP;
        end
        check_eq({tag, "_cycles"}, cyc, RUN_CYC);
        check_eq({tag, "_idle"}, bus.busy, 0);
        model_run();
        check_eq({tag, "_sat"}, bus.sat, msat);
        read_all(tag);
        check_eq({tag, "_done_held"}, bus.done, 1);
    endtask

    initial begin
        int cyc;
        bus.op = OP_NOP; bus.ch = 1'b0; bus.addr = 0; bus.din = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_y", bus.y, 0);
        check_eq("rst_y_valid", bus.y_valid, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_sat", bus.sat, 0);
        check_eq("rst_err", bus.err, 0);
        reset = 1'b1;

        // Impulse response on channel 0, silence on channel 1.
        for (int k = 0; k < NTAPS; k++) wr_coef(k, 16'(k + 1));
        for (int i = 0; i < NSAMP; i++) begin
            wr_sample(0, i, (i == 0) ? 16'h1 : 16'h0);
            wr_sample(1, i, 16'h0);
        end
        run_check(1'b0, "imp");

        // Step on channel 1 with a refused write during the run.
        for (int i = 0; i < NSAMP; i++) wr_sample(1, i, 16'h1);
        run_check(1'b1, "step");

        do_op(OP_RD_OUT, 1'b0, 8, 16'h0);
        check_eq("rd_oob_err", bus.err, 1);
        check_eq("rd_oob_vld", bus.y_valid, 1);
        check_eq("rd_oob_y", bus.y, 0);
        do_op(3'b111, 1'b0, 0, 16'h0);
        check_eq("illegal_err", bus.err, 1);
        do_op(OP_WR_COEF, 1'b0, 4, 16'h7777);
        check_eq("coef_oob_err", bus.err, 1);
        do_op(OP_WR_SAMPLE, 1'b1, 8, 16'h7777);
        check_eq("samp_oob_err", bus.err, 1);
        do_op(OP_NOP, 1'b0, 0, 16'h0);
        check_eq("nop_err", bus.err, 0);

        // Positive and negative saturation.
        for (int k = 0; k < NTAPS; k++) wr_coef(k, 16'h7FFF);
        for (int i = 0; i < NSAMP; i++) wr_sample(0, i, 16'h7FFF);
        run_check(1'b0, "satp");
        for (int i = 0; i < NSAMP; i++) wr_sample(0, i, 16'h8001);
        run_check(1'b0, "satn");

        // Reset mid-run, then a clean rerun over the same memories.
        do_op(OP_START, 1'b0, 0, 16'h0);
        repeat (29) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_busy", bus.busy, 0);
        check_eq("midrst_done", bus.done, 0);
        reset = 1'b1;
        run_check(1'b0, "rerun");

        // Random coefficients and samples.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NTAPS; k++)
                wr_coef(k, (r == 0) ? 16'($urandom_range(0, 511) - 256) : 16'($urandom));
            for (int c = 0; c < NCH; c++)
                for (int i = 0; i < NSAMP; i++)
                    wr_sample(c, i, (r == 0) ? 16'($urandom_range(0, 1023) - 512) : 16'($urandom));
            run_check(1'b0, $sformatf("rnd%0d", r));
        end

        // Clear wipes samples and outputs but keeps coefficients.
        do_op(OP_CLEAR, 1'b0, 0, 16'h0);
        cyc = 0;
        while (bus.busy && cyc < LIMIT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("clr_cycles", cyc, NSAMP);
        check_eq("clr_done", bus.done, 0);
        check_eq("clr_sat", bus.sat, 0);
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < NSAMP; i++) begin
                mx[c][i]   = '0;
                mout[c][i] = '0;
            end
        read_all("clr");
        run_check(1'b0, "postclr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
